pwm_duty_ramp_ctrl: RTL and testbench

Duty-cycle sequencer placed in front of the 10-step PWM generator. It accepts a target duty over a valid/ready handshake and walks the generator's duty setpoint toward it one step (10%) at a time. Each step is aligned to a PWM period boundary and spaced STEP_PERIODS periods apart, giving soft-start/soft-stop. An emergency-stop input forces duty to 0 immediately and aborts any ramp.

---
 rtl/pwm_duty_ramp_ctrl_if.sv | 10 +
 rtl/pwm_duty_ramp_ctrl.sv | 89 ++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// pwm_duty_ramp_ctrl_if: target-duty valid/ready handshake into the ramp controller
interface pwm_duty_ramp_ctrl_if #(
    parameter int DUTY_W = 4
);
    logic              tgt_valid;
    logic [DUTY_W-1:0] tgt_duty;
    logic              tgt_ready;
    modport master (output tgt_valid, tgt_duty, input tgt_ready);
    modport slave (input tgt_valid, tgt_duty, output tgt_ready);
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl: steps the PWM duty setpoint toward a target one code per STEP_PERIODS periods
module pwm_duty_ramp_ctrl #(
    parameter int DUTY_W       = 4,
    parameter int DUTY_MAX     = 10,
    parameter int INIT_DUTY    = 5,
    parameter int STEP_PERIODS = 4,
    parameter int CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pwm_period_end,
    input  logic                   estop,
    pwm_duty_ramp_ctrl_if.slave    tgt,
    output logic [DUTY_W-1:0]      duty,
    output logic                   duty_update,
    output logic                   busy,
    output logic                   done,
    output logic                   err_range
);
    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, ESTOP} state_t;
    localparam logic [DUTY_W-1:0] MAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT = DUTY_W'(INIT_DUTY);
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(STEP_PERIODS - 1);
    state_t state, state_n;
    logic [DUTY_W-1:0] target, target_n, duty_n, eff, step;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic upd_n, done_n, err_n;
    assign tgt.tgt_ready = (state == IDLE) && !estop;
    assign busy = state != IDLE;
    assign eff = tgt.tgt_duty > MAX ? MAX : tgt.tgt_duty;
    assign step = state == RAMP_UP ? duty + DUTY_W'(1) : duty - DUTY_W'(1);
    always_comb begin
        state_n = state;
        duty_n = duty;
        target_n = target;
        cnt_n = cnt;
        upd_n = 1'b0;
        done_n = 1'b0;
        err_n = 1'b0;
        if (estop) begin
            state_n = ESTOP;
            duty_n = '0;
            target_n = '0;
            cnt_n = '0;
            upd_n = duty != '0;
        end else if (state == ESTOP) begin
            state_n = IDLE;
            cnt_n = '0;
        end else if (state == IDLE) begin
            if (tgt.tgt_valid) begin
                target_n = eff;
                cnt_n = '0;
                err_n = tgt.tgt_duty > MAX;
                done_n = eff == duty;
                state_n = eff > duty ? RAMP_UP : eff < duty ? RAMP_DOWN : IDLE;
            end
        end else if (pwm_period_end) begin
            // the step that lands on the target also closes the ramp in the same cycle
            if (cnt == LAST) begin
                duty_n = step;
                upd_n = 1'b1;
                cnt_n = '0;
                done_n = step == target;
                state_n = step == target ? IDLE : state;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            duty <= INIT;
            target <= INIT;
            cnt <= '0;
            duty_update <= 1'b0;
            done <= 1'b0;
            err_range <= 1'b0;
        end else begin
            state <= state_n;
            duty <= duty_n;
            target <= target_n;
            cnt <= cnt_n;
            duty_update <= upd_n;
            done <= done_n;
            err_range <= err_n;
        end
    end
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb_pwm_duty_ramp_ctrl: scoreboard bench, slow-step (4) main instance plus a step-every-period instance
module tb_pwm_duty_ramp_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pe = 1'b0;
    logic pe1 = 1'b0;
    logic estop = 1'b0;
    logic estop1 = 1'b0;
    logic [3:0] duty, duty1;
    logic upd, busy, done, err;
    logic upd1, busy1, done1, err1;
    int vectors = 0;
    int miscompares = 0;
    logic [3:0] exp_upd[$];
    logic [3:0] exp_done[$];
    logic exp_err[$];
    logic [3:0] e;
    pwm_duty_ramp_ctrl_if #(.DUTY_W(4)) t0 ();
    pwm_duty_ramp_ctrl_if #(.DUTY_W(4)) t1 ();
    always #5 clk = ~clk;
    pwm_duty_ramp_ctrl #(.STEP_PERIODS(4)) u0 (
        .clk(clk), .reset(reset), .pwm_period_end(pe), .estop(estop), .tgt(t0.slave),
        .duty(duty), .duty_update(upd), .busy(busy), .done(done), .err_range(err)
    );
    pwm_duty_ramp_ctrl #(.STEP_PERIODS(1)) u1 (
        .clk(clk), .reset(reset), .pwm_period_end(pe1), .estop(estop1), .tgt(t1.slave),
        .duty(duty1), .duty_update(upd1), .busy(busy1), .done(done1), .err_range(err1)
    );
    always @(negedge clk) begin
        if (reset) begin
            if (upd) begin
                vectors++;
                if (exp_upd.size() == 0) begin
                    miscompares++;
                    $display("FAIL upd_unexpected: duty_update with duty=%0d, none expected", duty);
                end else begin
                    e = exp_upd.pop_front();
                    if (duty !== e) begin
                        miscompares++;
                        $display("FAIL upd_duty: got %0d want %0d", duty, e);
                    end
                end
            end
            if (done) begin
                vectors++;
                if (exp_done.size() == 0) begin
                    miscompares++;
                    $display("FAIL done_unexpected: done with duty=%0d, none expected", duty);
                end else begin
                    e = exp_done.pop_front();
                    if (duty !== e) begin
                        miscompares++;
                        $display("FAIL done_duty: got %0d want %0d", duty, e);
                    end
                end
            end
            if (err) begin
                vectors++;
                if (exp_err.size() == 0) begin
                    miscompares++;
                    $display("FAIL err_unexpected: err_range=1 want 0");
                end else begin
                    void'(exp_err.pop_front());
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse(input int n);
        repeat (n) begin
            pe = 1'b1;
            tick();
            pe = 1'b0;
            tick();
        end
    endtask
    task automatic send(input logic [3:0] v, input logic with_pe);
        int k = 0;
        while (!t0.tgt_ready && k < 100) begin
            tick();
            k++;
        end
        if (k == 100) begin
            miscompares++;
            $display("FAIL send_timeout: tgt_ready=0 want 1");
        end
        t0.tgt_valid = 1'b1;
        t0.tgt_duty = v;
        pe = with_pe;
        tick();
        t0.tgt_valid = 1'b0;
        pe = 1'b0;
    endtask
    task automatic test_reset();
        repeat (2) tick();
        vectors++;
        if ({duty, t0.tgt_ready, busy, upd, done, err} !== {4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got duty=%0d rdy=%b busy=%b upd=%b done=%b err=%b want 5 1 0 0 0 0",
                     duty, t0.tgt_ready, busy, upd, done, err);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({duty, duty1, busy1} !== {4'd5, 4'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release: got duty=%0d duty1=%0d busy1=%b want 5 5 0", duty, duty1, busy1);
        end
    endtask
    task automatic test_ramp_up();
        exp_upd.push_back(4'd6);
        exp_upd.push_back(4'd7);
        exp_upd.push_back(4'd8);
        exp_done.push_back(4'd8);
        send(4'd8, 1'b1);
        vectors++;
        if ({busy, t0.tgt_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL ramp_up_busy: got busy=%b rdy=%b want 1 0", busy, t0.tgt_ready);
        end
        for (int i = 1; i <= 12; i++) begin
            pulse(1);
            vectors++;
            if (duty !== 4'(5 + i / 4)) begin
                miscompares++;
                $display("FAIL ramp_up_step%0d: got duty=%0d want %0d", i, duty, 5 + i / 4);
            end
        end
        vectors++;
        if ({busy, t0.tgt_ready} !== 2'b01 || exp_upd.size() + exp_done.size() != 0) begin
            miscompares++;
            $display("FAIL ramp_up_end: got busy=%b rdy=%b pending=%0d want 0 1 0",
                     busy, t0.tgt_ready, exp_upd.size() + exp_done.size());
        end
    endtask
    task automatic test_ramp_down_fast();
        t1.tgt_valid = 1'b1;
        t1.tgt_duty = 4'd0;
        tick();
        t1.tgt_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pe1 = 1'b1;
            tick();
            vectors++;
            if ({duty1, upd1, done1} !== {4'(i < 5 ? 4 - i : 0), i < 5, i == 4}) begin
                miscompares++;
                $display("FAIL ramp_down_p%0d: got duty=%0d upd=%b done=%b want %0d %b %b",
                         i, duty1, upd1, done1, i < 5 ? 4 - i : 0, i < 5, i == 4);
            end
            pe1 = 1'b0;
            tick();
        end
    endtask
    task automatic test_err_range();
        exp_upd.push_back(4'd9);
        exp_done.push_back(4'd9);
        send(4'd9, 1'b0);
        pulse(4);
        exp_err.push_back(1'b1);
        exp_upd.push_back(4'd10);
        exp_done.push_back(4'd10);
        send(4'd15, 1'b0);
        pulse(8);
        vectors++;
        if ({duty, busy} !== {4'd10, 1'b0}) begin
            miscompares++;
            $display("FAIL err_clamp: got duty=%0d busy=%b want 10 0", duty, busy);
        end
        exp_done.push_back(4'd10);
        send(4'd10, 1'b0);
        tick();
        vectors++;
        if ({duty, busy} !== {4'd10, 1'b0} || exp_upd.size() + exp_done.size() + exp_err.size() != 0) begin
            miscompares++;
            $display("FAIL err_same: got duty=%0d busy=%b pending=%0d want 10 0 0",
                     duty, busy, exp_upd.size() + exp_done.size() + exp_err.size());
        end
    endtask
    task automatic test_held_valid();
        foreach (exp_upd[i]) exp_upd.delete(i);
        exp_upd = '{4'd9, 4'd8, 4'd7, 4'd8, 4'd9};
        exp_done = '{4'd7, 4'd9};
        t0.tgt_valid = 1'b1;
        t0.tgt_duty = 4'd7;
        tick();
        t0.tgt_duty = 4'd9;
        pulse(1);
        vectors++;
        if (t0.tgt_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL held_ready: got %b want 0", t0.tgt_ready);
        end
        pulse(11);
        t0.tgt_valid = 1'b0;
        vectors++;
        if ({duty, busy} !== {4'd7, 1'b1}) begin
            miscompares++;
            $display("FAIL held_accept: got duty=%0d busy=%b want 7 1", duty, busy);
        end
        pulse(8);
        vectors++;
        if ({duty, busy} !== {4'd9, 1'b0} || exp_upd.size() + exp_done.size() != 0) begin
            miscompares++;
            $display("FAIL held_end: got duty=%0d busy=%b pending=%0d want 9 0 0",
                     duty, busy, exp_upd.size() + exp_done.size());
        end
    endtask
    task automatic test_estop();
        exp_upd = '{4'd8, 4'd7};
        send(4'd3, 1'b0);
        pulse(8);
        exp_upd.push_back(4'd0);
        estop = 1'b1;
        tick();
        vectors++;
        if ({duty, busy, t0.tgt_ready} !== {4'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL estop_enter: got duty=%0d busy=%b rdy=%b want 0 1 0", duty, busy, t0.tgt_ready);
        end
        pulse(4);
        estop = 1'b0;
        tick();
        vectors++;
        if ({duty, busy, t0.tgt_ready} !== {4'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL estop_release: got duty=%0d busy=%b rdy=%b want 0 0 1", duty, busy, t0.tgt_ready);
        end
        estop = 1'b1;
        t0.tgt_valid = 1'b1;
        t0.tgt_duty = 4'd4;
        tick();
        t0.tgt_valid = 1'b0;
        tick();
        vectors++;
        if ({duty, busy} !== {4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL estop_vs_valid: got duty=%0d busy=%b want 0 1", duty, busy);
        end
        estop = 1'b0;
        tick();
        exp_done.push_back(4'd0);
        send(4'd0, 1'b0);
        tick();
        vectors++;
        if ({duty, busy} !== {4'd0, 1'b0} || exp_upd.size() + exp_done.size() != 0) begin
            miscompares++;
            $display("FAIL estop_target0: got duty=%0d busy=%b pending=%0d want 0 0 0",
                     duty, busy, exp_upd.size() + exp_done.size());
        end
    endtask
    task automatic test_reset_mid_ramp();
        exp_upd = '{4'd1, 4'd2, 4'd3};
        send(4'd4, 1'b0);
        pulse(12);
        reset = 1'b0;
        #2;
        vectors++;
        if ({duty, busy, t0.tgt_ready} !== {4'd5, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_async: got duty=%0d busy=%b rdy=%b want 5 0 1", duty, busy, t0.tgt_ready);
        end
        tick();
        reset = 1'b1;
        pulse(8);
        vectors++;
        if ({duty, busy} !== {4'd5, 1'b0} || exp_upd.size() + exp_done.size() != 0) begin
            miscompares++;
            $display("FAIL reset_no_resume: got duty=%0d busy=%b pending=%0d want 5 0 0",
                     duty, busy, exp_upd.size() + exp_done.size());
        end
    endtask
    initial begin
        t0.tgt_valid = 1'b0;
        t0.tgt_duty = 4'd0;
        t1.tgt_valid = 1'b0;
        t1.tgt_duty = 4'd0;
        test_reset();
        test_ramp_up();
        test_ramp_down_fast();
        test_err_range();
        test_held_valid();
        test_estop();
        test_reset_mid_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, want finished");
        $fatal(1);
    end
endmodule
